// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x outright, or when they tie and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;

  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result fills from the MSB side so that after WIDTH shifts bit 0 lands in bit 0.
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= bo_bit;
          res_sr <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff  <= res_next;
            bout  <= bo_bit;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed) and WIDTH=2 (exhaustive).
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         due;
  } exp8_t;

  typedef struct {
    logic [1:0] diff;
    logic       bout;
    int         due;
  } exp2_t;

  logic       clk, clk_en, rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start2, bin2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  exp8_t q8[$];
  exp2_t q2[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL w8_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("w8_diff", 32'(diff8), 32'(e.diff));
        chk("w8_bout", 32'(bout8), 32'(e.bout));
        chk("w8_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL w2_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp2_t e;
        e = q2.pop_front();
        chk("w2_diff", 32'(diff2), 32'(e.diff));
        chk("w2_bout", 32'(bout2), 32'(e.bout));
        chk("w2_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called with clk low; returns just after the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input bit expect_done);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk);
    #1;
    if (expect_done) q8.push_back('{ed, eb, cyc + 8});
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    bin8 = 1'($urandom);
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                        input logic [1:0] ed, input logic eb);
    a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
    @(posedge clk);
    #1;
    q2.push_back('{ed, eb, cyc + 2});
    start2 = 1'b0;
    a2 = 2'($urandom);
    b2 = 2'($urandom);
    bin2 = 1'($urandom);
  endtask

  // Returns at the negedge of the cycle where busy has dropped (the done cycle).
  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (busy8 !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy8 !== 1'b0) begin
      total++;
      $display("FAIL w8_timeout: got busy=%b after 40 cycles expected 0", busy8);
    end
  endtask

  task automatic wait_idle2();
    int n = 0;
    @(negedge clk);
    while (busy2 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy2 !== 1'b0) begin
      total++;
      $display("FAIL w2_timeout: got busy=%b after 20 cycles expected 0", busy2);
    end
  endtask

  initial begin
    clk = 1'b0; clk_en = 1'b0; rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

    // Reset with the clock stopped: outputs must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy8), 32'h0);
    chk("rst_done", 32'(done8), 32'h0);
    chk("rst_diff", 32'(diff8), 32'h00);
    chk("rst_bout", 32'(bout8), 32'h0);
    chk("rst_w2_diff", 32'(diff2), 32'h0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1);
    wait_idle8();
    issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_idle8();
    issue8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);
    wait_idle8();
    @(negedge clk);

    // A start during the run must be ignored.
    issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    repeat (4) @(negedge clk);

    // Second op requested in the done cycle of the first.
    issue8(8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b1);
    wait_idle8();
    issue8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b1);
    wait_idle8();
    @(negedge clk);

    // Abort mid-operation.
    issue8(8'h5A, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'h0);
    chk("abort_done", 32'(done8), 32'h0);
    chk("abort_diff", 32'(diff8), 32'h00);
    chk("abort_bout", 32'(bout8), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done_diff", 32'(diff8), 32'h00);
    issue8(8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle8();
    @(negedge clk);

    // WIDTH=2 exhaustive against {bout,diff} = a - b - bin modulo 8.
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ta, tb;
      logic       tbi;
      logic [2:0] r;
      ta = 2'(i >> 3);
      tb = 2'(i >> 1);
      tbi = 1'(i);
      r = {1'b0, ta} - {1'b0, tb} - {2'b00, tbi};
      issue2(ta, tb, tbi, r[1:0], r[2]);
      wait_idle2();
    end

    repeat (5) @(negedge clk);
    chk("w8_queue_drained", 32'(q8.size()), 32'h0);
    chk("w2_queue_drained", 32'(q2.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
